// File: rtl/seg_mon_pkg.sv
// Shared definitions for the seven-segment sequence monitor.
//   - mon_state_t : monitor FSM states
//   - SEG_n       : active-low segment patterns (bit0=a .. bit6=g) for digits 0..9
//   - SEG_BLANK   : all segments off
//   - seg_encode  : digit -> pattern helper, handy for stimulus in other benches
package seg_mon_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } mon_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        logic [6:0] pat;
        case (value)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of an active-low seven-segment pattern to a decimal digit.
// Ports:
//   hex_in : 7-bit active-low segment bus (bit0=a .. bit6=g)
//   valid  : 1 when hex_in is one of the ten standard digit patterns
//   digit  : decoded value 0..9 (0 when not valid)
module seg7_decode
    import seg_mon_pkg::*;
(
    input  logic [6:0] hex_in,
    output logic       valid,
    output logic [3:0] digit
);

    always_comb begin
        valid = 1'b1;
        digit = 4'd0;
        case (hex_in)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_sequence_monitor.sv
// Watches the HEX bus of the digit-sequencing display FSM, decodes each sampled
// pattern, tracks the FSM's position in the programmed sequence and flags
// wrong-direction advances and illegal patterns.
// Parameters:
//   SEQ_LEN : digits in the cycle (2..8)
//   SEQ     : packed sequence, element 0 in bits [3:0]
// Ports:
//   clk, rst_n : clock, async active-low reset
//   hex_in     : active-low segment bus
//   dir        : 0 = forward (index+1), 1 = backward (index-1)
//   sample_en  : strobe, hex_in/dir valid this cycle
//   digit      : last validly decoded digit
//   pos        : current sequence index
//   locked     : position known
//   step_ok    : pulse, correct advance
//   dir_err    : pulse, legal digit but wrong successor
//   bad_pat    : pulse, invalid pattern or digit outside SEQ
//   err_count  : saturating count of dir_err + bad_pat
//
// state    | meaning
// UNLOCKED | position unknown since reset; first in-sequence digit locks
// LOCKED   | position known; each sample checked against the expected successor
// FAULT    | lost track after an illegal sample; next in-sequence digit relocks
module seg_sequence_monitor
    import seg_mon_pkg::*;
#(
    parameter int                     SEQ_LEN = 5,
    parameter logic [4*SEQ_LEN-1:0]   SEQ     = 20'h97531
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] hex_in,
    input  logic       dir,
    input  logic       sample_en,
    output logic [3:0] digit,
    output logic [2:0] pos,
    output logic       locked,
    output logic       step_ok,
    output logic       dir_err,
    output logic       bad_pat,
    output logic [7:0] err_count
);

    localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 1);

    mon_state_t state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic [2:0] pos_q, pos_d;
    logic       step_ok_q, step_ok_d;
    logic       dir_err_q, dir_err_d;
    logic       bad_pat_q, bad_pat_d;
    logic [7:0] err_count_q;
    logic       err_inc;

    logic       dec_valid;
    logic [3:0] dec_digit;
    logic       found;
    logic [2:0] found_idx;
    logic [2:0] expected_idx;

    seg7_decode u_decode (
        .hex_in (hex_in),
        .valid  (dec_valid),
        .digit  (dec_digit)
    );

    // Entries of SEQ are distinct, so at most one index can match.
    always_comb begin
        found     = 1'b0;
        found_idx = 3'd0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (dec_valid && (SEQ[4*i +: 4] == dec_digit)) begin
                found     = 1'b1;
                found_idx = 3'(i);
            end
        end
    end

    // Wrap by compare-and-select; SEQ_LEN need not be a power of two.
    always_comb begin
        if (!dir) begin
            expected_idx = (pos_q == LAST_IDX) ? 3'd0 : pos_q + 3'd1;
        end else begin
            expected_idx = (pos_q == 3'd0) ? LAST_IDX : pos_q - 3'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        digit_d   = digit_q;
        step_ok_d = 1'b0;
        dir_err_d = 1'b0;
        bad_pat_d = 1'b0;
        err_inc   = 1'b0;

        if (sample_en) begin
            if (dec_valid) begin
                digit_d = dec_digit;
            end
            case (state_q)
                LOCKED: begin
                    if (!found) begin
                        bad_pat_d = 1'b1;
                        err_inc   = 1'b1;
                        state_d   = FAULT;
                    end else if (found_idx == expected_idx) begin
                        step_ok_d = 1'b1;
                        pos_d     = found_idx;
                    end else begin
                        dir_err_d = 1'b1;
                        err_inc   = 1'b1;
                        pos_d     = found_idx;
                    end
                end
                default: begin
                    // UNLOCKED and FAULT recover identically.
                    if (found) begin
                        pos_d   = found_idx;
                        state_d = LOCKED;
                    end else begin
                        bad_pat_d = 1'b1;
                        err_inc   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            pos_q       <= 3'd0;
            digit_q     <= 4'd0;
            step_ok_q   <= 1'b0;
            dir_err_q   <= 1'b0;
            bad_pat_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            digit_q   <= digit_d;
            step_ok_q <= step_ok_d;
            dir_err_q <= dir_err_d;
            bad_pat_q <= bad_pat_d;
            if (err_inc && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign digit     = digit_q;
    assign pos       = pos_q;
    assign locked    = (state_q == LOCKED);
    assign step_ok   = step_ok_q;
    assign dir_err   = dir_err_q;
    assign bad_pat   = bad_pat_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_seg_sequence_monitor.sv
// Bench for seg_sequence_monitor with default parameters (sequence 1,3,5,7,9).
module tb_seg_sequence_monitor;

    logic       clk;
    logic       rst_n;
    logic [6:0] hex_in;
    logic       dir;
    logic       sample_en;
    logic [3:0] digit;
    logic [2:0] pos;
    logic       locked;
    logic       step_ok;
    logic       dir_err;
    logic       bad_pat;
    logic [7:0] err_count;

    seg_sequence_monitor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hex_in    (hex_in),
        .dir       (dir),
        .sample_en (sample_en),
        .digit     (digit),
        .pos       (pos),
        .locked    (locked),
        .step_ok   (step_ok),
        .dir_err   (dir_err),
        .bad_pat   (bad_pat),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference data, written independently of the design package.
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int seq_arr [5] = '{1, 3, 5, 7, 9};
    localparam int L = 5;
    localparam logic [6:0] BLANK = 7'h7F;

    // Model: m_mode 0 = no position, 1 = tracking, 2 = lost after bad sample.
    int m_mode, m_pos, m_digit, m_err;
    int e_step, e_derr, e_bad;

    function automatic int decode(input logic [6:0] h);
        for (int k = 0; k < 10; k++) if (seg_tab[k] == h) return k;
        return -1;
    endfunction

    function automatic int seq_index(input int v);
        if (v < 0) return -1;
        for (int k = 0; k < L; k++) if (seq_arr[k] == v) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_digit = 0; m_err = 0;
        e_step = 0; e_derr = 0; e_bad = 0;
    endtask

    task automatic count_error();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_sample(input logic [6:0] h, input logic d);
        int v, idx, want;
        v   = decode(h);
        idx = seq_index(v);
        e_step = 0; e_derr = 0; e_bad = 0;
        if (v >= 0) m_digit = v;
        if (m_mode == 1) begin
            if (idx < 0) begin
                e_bad = 1; count_error(); m_mode = 2;
            end else begin
                want = d ? (m_pos + L - 1) % L : (m_pos + 1) % L;
                if (idx == want) e_step = 1;
                else begin e_derr = 1; count_error(); end
                m_pos = idx;
            end
        end else begin
            if (idx >= 0) begin
                m_pos = idx; m_mode = 1;
            end else begin
                e_bad = 1; count_error();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".digit"},     {4'd0, digit},     8'(m_digit));
        chk({ctx, ".pos"},       {5'd0, pos},       8'(m_pos));
        chk({ctx, ".locked"},    {7'd0, locked},    8'(m_mode == 1));
        chk({ctx, ".step_ok"},   {7'd0, step_ok},   8'(e_step));
        chk({ctx, ".dir_err"},   {7'd0, dir_err},   8'(e_derr));
        chk({ctx, ".bad_pat"},   {7'd0, bad_pat},   8'(e_bad));
        chk({ctx, ".err_count"}, err_count,         8'(m_err));
    endtask

    // Called at a falling edge; strobes one sample and checks at the next falling edge.
    task automatic sample(input string ctx, input logic [6:0] h, input logic d);
        hex_in    = h;
        dir       = d;
        sample_en = 1'b1;
        model_sample(h, d);
        @(negedge clk);
        check_all(ctx);
        sample_en = 1'b0;
    endtask

    task automatic idle(input string ctx, input int n);
        for (int k = 0; k < n; k++) begin
            hex_in = 7'($urandom);
            dir    = 1'($urandom);
            e_step = 0; e_derr = 0; e_bad = 0;
            @(negedge clk);
            check_all(ctx);
        end
    endtask

    function automatic logic [6:0] illegal_pattern();
        logic [6:0] p;
        if ($urandom_range(0, 1) == 0) p = seg_tab[2 * $urandom_range(0, 4)];
        else p = 7'($urandom);
        if (seq_index(decode(p)) >= 0) p = BLANK;
        return p;
    endfunction

    initial begin
        rst_n     = 1'b0;
        hex_in    = BLANK;
        dir       = 1'b0;
        sample_en = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        // Forward walk with wrap.
        sample("fwd1", seg_tab[1], 1'b0);
        sample("fwd3", seg_tab[3], 1'b0);
        sample("fwd5", seg_tab[5], 1'b0);
        sample("fwd7", seg_tab[7], 1'b0);
        sample("fwd9", seg_tab[9], 1'b0);
        sample("fwd1w", seg_tab[1], 1'b0);

        // Backward with wrap from index 0.
        sample("bwd9", seg_tab[9], 1'b1);
        sample("bwd7", seg_tab[7], 1'b1);
        sample("bwd5", seg_tab[5], 1'b1);
        sample("bwd3", seg_tab[3], 1'b1);

        // Wrong successor resyncs, then stepping resumes.
        sample("derr7", seg_tab[7], 1'b0);
        sample("after9", seg_tab[9], 1'b0);

        // Illegal patterns drop lock, digit holds on blank.
        sample("blank", BLANK, 1'b0);
        sample("notseq2", seg_tab[2], 1'b0);
        sample("relock5", seg_tab[5], 1'b0);

        idle("idle", 20);

        // Back-to-back illegal samples saturate the counter.
        for (int k = 0; k < 300; k++) sample("sat", illegal_pattern(), 1'($urandom));
        idle("idle2", 2);

        // Reset during a dir_err pulse.
        sample("relock5b", seg_tab[5], 1'b0);
        sample("repeat5", seg_tab[5], 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        sample("rst_lock5", seg_tab[5], 1'b0);

        // Randomized mix of in-sequence, out-of-sequence and junk samples.
        for (int k = 0; k < 400; k++) begin
            int kind;
            logic [6:0] p;
            kind = $urandom_range(0, 9);
            if (kind < 6) p = seg_tab[seq_arr[$urandom_range(0, L - 1)]];
            else if (kind < 8) p = seg_tab[$urandom_range(0, 9)];
            else p = 7'($urandom);
            sample("rand", p, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle("rand_idle", $urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
